lj_force_collector: RTL and testbench



---
 rtl/lj_force_collector_if.sv | 24 ++
 rtl/lj_force_collector.sv | 201 ++++++++++++++++++++
 tb/tb_lj_force_collector.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lj_force_collector_if.sv
// Output stream of the LJ force collector.
// Carries one {Z,Y,X} force triple per valid/ready handshake.
interface lj_force_collector_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/lj_force_collector.sv
// Force sink: buffers LJ force triples, then streams them out.
// Optional macro FORCE_NAN_CHECK_EN adds a NaN/Inf triple counter.
module lj_force_collector #(
  parameter int DATA_WIDTH            = 32,
  parameter int REF_PARTICLE_NUM      = 10,
  parameter int NEIGHBOR_PARTICLE_NUM = 10,
  parameter int BUF_DEPTH             =
    REF_PARTICLE_NUM * NEIGHBOR_PARTICLE_NUM,
  parameter int BUF_ADDR_WIDTH        = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     LJ_Force_X,
  input  logic [DATA_WIDTH-1:0]     LJ_Force_Y,
  input  logic [DATA_WIDTH-1:0]     LJ_Force_Z,
  input  logic                      forceoutput_valid,
  input  logic                      done,
  input  logic                      dump_req,
  lj_force_collector_if.master      out,
  output logic                      collect_done,
  output logic [BUF_ADDR_WIDTH:0]   pair_count,
  output logic                      overflow
`ifdef FORCE_NAN_CHECK_EN
  ,
  output logic [BUF_ADDR_WIDTH:0]   nan_count
`endif
);

  localparam int CW = BUF_ADDR_WIDTH + 1;
  localparam int EW = 3 * DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] ONE   = CW'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] READY   = 2'd2;
  localparam logic [1:0] DUMP    = 2'd3;

  logic [1:0]    state;
  logic [EW-1:0] mem [BUF_DEPTH];
  logic [CW-1:0] rd_ptr;
  logic [EW-1:0] ram_q;
  logic          ram_v;
  logic          ram_last;
  logic [EW-1:0] skid_q;
  logic          skid_v;
  logic          skid_last;
  logic [EW-1:0] data_q;
  logic          valid_q;
  logic          last_q;
  logic          has_room;
  logic          wr_en;
  logic          ovf_hit;
  logic          clr;
  logic          pop;
  logic          rd_en;
  logic [1:0]    inflight;

  assign has_room = pair_count < DEPTH;
  assign wr_en    = (state == COLLECT) &&
                    forceoutput_valid && has_room;
  assign ovf_hit  = (state == COLLECT) &&
                    forceoutput_valid && !has_room;
  assign clr      = start &&
                    ((state == IDLE) || (state == READY));
  assign pop      = valid_q & out.out_ready;

  // Reads in flight: RAM stage + output reg + skid.
  // Issue only if the two-slot output side can absorb it.
  assign inflight = {1'b0, ram_v} + {1'b0, valid_q} +
                    {1'b0, skid_v};
  assign rd_en    = (state == DUMP) &&
                    (rd_ptr < pair_count) &&
                    ((inflight <= 2'd1) ||
                     (pop && (inflight == 2'd2)));

  assign out.out_data  = data_q;
  assign out.out_valid = valid_q;
  assign out.out_last  = last_q;
  assign collect_done  = (state == READY) || (state == DUMP);

  // Run-level state machine; start takes priority in READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state <= COLLECT;
        COLLECT: if (done) state <= READY;
        READY: begin
          if (start)
            state <= COLLECT;
          else if (dump_req && (pair_count != '0))
            state <= DUMP;
        end
        DUMP:    if (pop && last_q) state <= READY;
        default: state <= IDLE;
      endcase
    end
  end

  // Capture counters; pair_count doubles as write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_count <= '0;
      overflow   <= 1'b0;
    end else if (clr) begin
      pair_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)   pair_count <= pair_count + ONE;
      if (ovf_hit) overflow   <= 1'b1;
    end
  end

  // Result buffer with registered read port (not reset).
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[pair_count[BUF_ADDR_WIDTH-1:0]] <=
        {LJ_Force_Z, LJ_Force_Y, LJ_Force_X};
    if (rd_en)
      ram_q <= mem[rd_ptr[BUF_ADDR_WIDTH-1:0]];
  end

  // Read address sequencing and RAM-stage tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      ram_v    <= 1'b0;
      ram_last <= 1'b0;
    end else if (state != DUMP) begin
      rd_ptr   <= '0;
      ram_v    <= 1'b0;
      ram_last <= 1'b0;
    end else begin
      ram_v <= rd_en;
      if (rd_en) begin
        rd_ptr   <= rd_ptr + ONE;
        ram_last <= (rd_ptr == pair_count - ONE);
      end
    end
  end

  // Output register plus one-entry skid; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      skid_q    <= '0;
      skid_v    <= 1'b0;
      skid_last <= 1'b0;
    end else if (state != DUMP) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      skid_v  <= 1'b0;
    end else if (pop || !valid_q) begin
      if (skid_v) begin
        data_q    <= skid_q;
        last_q    <= skid_last;
        valid_q   <= 1'b1;
        skid_v    <= ram_v;
        skid_q    <= ram_q;
        skid_last <= ram_last;
      end else begin
        valid_q <= ram_v;
        last_q  <= ram_v & ram_last;
        if (ram_v) data_q <= ram_q;
      end
    end else if (ram_v) begin
      skid_v    <= 1'b1;
      skid_q    <= ram_q;
      skid_last <= ram_last;
    end
  end

`ifdef FORCE_NAN_CHECK_EN
  localparam int EXP_W = (DATA_WIDTH == 64) ? 11 :
                         (DATA_WIDTH == 16) ? 5 : 8;

  function automatic logic is_nan(
    input logic [DATA_WIDTH-1:0] v
  );
    return &v[DATA_WIDTH-2 -: EXP_W];
  endfunction

  // Count captured triples with any NaN/Inf component.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nan_count <= '0;
    else if (clr)
      nan_count <= '0;
    else if (wr_en && (is_nan(LJ_Force_X) ||
                       is_nan(LJ_Force_Y) ||
                       is_nan(LJ_Force_Z)))
      nan_count <= nan_count + ONE;
  end
`endif

endmodule

// File: tb/tb_lj_force_collector.sv
// Bench for lj_force_collector: queue-based reference model,
// per-cycle output compare, randomized collect/dump runs.
module tb_lj_force_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] fx, fy, fz;
  logic        fvalid;
  logic        done;
  logic        dump_req;
  logic        collect_done;
  logic [7:0]  pair_count;
  logic        overflow;
`ifdef FORCE_NAN_CHECK_EN
  logic [7:0]  nan_count;
`endif

  lj_force_collector_if #(.DATA_WIDTH(32)) ob ();

  lj_force_collector dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .LJ_Force_X        (fx),
    .LJ_Force_Y        (fy),
    .LJ_Force_Z        (fz),
    .forceoutput_valid (fvalid),
    .done              (done),
    .dump_req          (dump_req),
    .out               (ob),
    .collect_done      (collect_done),
    .pair_count        (pair_count),
    .overflow          (overflow)
`ifdef FORCE_NAN_CHECK_EN
    ,
    .nan_count         (nan_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit f_nan(input logic [31:0] v);
    return v[30:23] == 8'hFF;
  endfunction

  // Reference model: 0 idle, 1 collecting, 2 ready, 3 dumping
  logic [95:0] m_q[$];
  int  m_phase = 0;
  int  m_idx   = 0;
  int  m_age   = 0;
  int  m_nan   = 0;
  bit  m_ovf   = 0;

  task automatic m_clear();
    m_phase = 1;
    m_q.delete();
    m_ovf = 0;
    m_nan = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0;
      m_q.delete();
      m_ovf = 0;
      m_nan = 0;
      m_idx = 0;
      m_age = 0;
    end else begin
      case (m_phase)
        0: if (start) m_clear();
        1: begin
          if (fvalid) begin
            if (m_q.size() < 100) begin
              m_q.push_back({fz, fy, fx});
              if (f_nan(fx) || f_nan(fy) || f_nan(fz))
                m_nan++;
            end else begin
              m_ovf = 1;
            end
          end
          if (done) m_phase = 2;
        end
        2: begin
          if (start) m_clear();
          else if (dump_req && m_q.size() > 0) begin
            m_phase = 3;
            m_idx = 0;
            m_age = 0;
          end
        end
        default: begin
          if (m_age >= 2 && ob.out_ready) begin
            m_idx++;
            if (m_idx == m_q.size()) m_phase = 2;
          end
          if (m_age < 2) m_age++;
        end
      endcase
    end
  end

  // Compare process: every cycle, just after the edge
  initial forever begin
    bit mv;
    @(posedge clk);
    #1;
    mv = (m_phase == 3) && (m_age >= 2);
    chk("out_valid", ob.out_valid, mv);
    chk("collect_done", collect_done, m_phase >= 2);
    chk("pair_count", pair_count, m_q.size());
    chk("overflow", overflow, m_ovf);
`ifdef FORCE_NAN_CHECK_EN
    chk("nan_count", nan_count, m_nan);
`endif
    if (mv) begin
      chk("out_data", ob.out_data, m_q[m_idx]);
      chk("out_last", ob.out_last, m_idx == m_q.size() - 1);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // mode 0 index pattern, 1 random, 2 NaN pattern,
  // 3 random with final valid on the done cycle
  task automatic collect(input int n, input int mode);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        fvalid = 1'b0;
        start  = (mode == 1) && ($urandom_range(0, 1) == 1);
        cyc();
      end
      start  = 1'b0;
      fvalid = 1'b1;
      case (mode)
        0: begin
          fx = i;
          fy = i + 32'h100;
          fz = i + 32'h200;
        end
        2: begin
          fx = $urandom & 32'h3FFF_FFFF;
          fy = (i == 0 || i == 2) ? 32'h7FC0_0000 :
               ($urandom & 32'h3FFF_FFFF);
          fz = (i == 0) ? 32'h7F80_0000 :
               ($urandom & 32'h3FFF_FFFF);
        end
        default: begin
          fx = $urandom;
          fy = $urandom;
          fz = $urandom;
        end
      endcase
      if (mode == 3 && i == n - 1) begin
        fx = 32'h3F80_0000;
        done = 1'b1;
      end
      cyc();
    end
    fvalid = 1'b0;
    if (mode != 3) begin
      done = 1'b1;
      cyc();
    end
    done = 1'b0;
    cyc();
  endtask

  // mode 0 ready high, 1 fixed 1,0,0,1,0,1 pattern, 2 random
  task automatic dump(input int mode);
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    dump_req = 1'b1;
    cyc();
    dump_req = 1'b0;
    for (int k = 0; k < 2000 && m_phase == 3; k++) begin
      case (mode)
        0: ob.out_ready = 1'b1;
        1: ob.out_ready = pat[k % 6];
        default: ob.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) begin
        fvalid   = 1'($urandom_range(0, 1));
        fx       = $urandom;
        done     = 1'($urandom_range(0, 1));
        start    = ($urandom_range(0, 7) == 0);
        dump_req = ($urandom_range(0, 7) == 0);
      end
      cyc();
    end
    fvalid   = 1'b0;
    done     = 1'b0;
    start    = 1'b0;
    dump_req = 1'b0;
    ob.out_ready = 1'b1;
    chk("dump_finished", m_phase == 3, 1'b0);
  endtask

  logic [95:0] ent;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fx = '0;
    fy = '0;
    fz = '0;
    fvalid = 1'b0;
    done = 1'b0;
    dump_req = 1'b0;
    ob.out_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_out_data", ob.out_data, 96'h0);
    chk("rst_out_valid", ob.out_valid, 1'b0);
    chk("rst_out_last", ob.out_last, 1'b0);
    chk("rst_collect_done", collect_done, 1'b0);
    chk("rst_pair_count", pair_count, 8'd0);
    chk("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    cyc();

    // basic run of a full buffer
    collect(100, 0);
    chk("basic_count", pair_count, 8'd100);
    chk("basic_collect_done", collect_done, 1'b1);
    chk("model_entry0", m_q[0], {32'h200, 32'h100, 32'h0});
    chk("model_entry99", m_q[99],
        {32'h263, 32'h163, 32'h63});
    dump(0);

    // backpressure
    collect(5, 1);
    chk("bp_count", pair_count, 8'd5);
    dump(1);

    // overflow, then a new start clears it
    collect(103, 1);
    chk("ovf_count", pair_count, 8'd100);
    chk("ovf_flag", overflow, 1'b1);
    dump(2);
    collect(3, 1);
    chk("ovf_cleared", overflow, 1'b0);
    chk("ovf_new_count", pair_count, 8'd3);
    dump(0);

    // last valid in the same cycle as done
    collect(7, 3);
    chk("simul_count", pair_count, 8'd7);
    ent = m_q[6];
    chk("simul_last_x", ent[31:0], 32'h3F80_0000);
    dump(2);

    // start and dump_req together: start wins
    start = 1'b1;
    dump_req = 1'b1;
    cyc();
    start = 1'b0;
    dump_req = 1'b0;
    chk("sd_collect_done", collect_done, 1'b0);
    chk("sd_no_valid", ob.out_valid, 1'b0);
    repeat (4) cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
    chk("empty_count", pair_count, 8'd0);
    chk("empty_done", collect_done, 1'b1);
    dump_req = 1'b1;
    cyc();
    dump_req = 1'b0;
    repeat (4) cyc();
    chk("empty_dump_ignored", ob.out_valid, 1'b0);

    // NaN/Inf pattern
    collect(4, 2);
    chk("model_nan", m_nan, 2);
`ifdef FORCE_NAN_CHECK_EN
    chk("nan_lit", nan_count, 8'd2);
`endif
    dump(2);

    // random runs with noise on idle inputs
    for (int r = 0; r < 8; r++) begin
      collect($urandom_range(1, 40), 1);
      fvalid = 1'b1;
      done = 1'b1;
      fx = $urandom;
      cyc();
      fvalid = 1'b0;
      done = 1'b0;
      dump(r % 3);
    end

    // reset while beat 3 is presented
    collect(6, 1);
    dump_req = 1'b1;
    cyc();
    dump_req = 1'b0;
    ob.out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (m_phase == 3 && m_age >= 2 && m_idx == 3) break;
      cyc();
    end
    chk("beat3_reached", m_idx, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ob.out_valid, 1'b0);
    chk("mid_rst_done", collect_done, 1'b0);
    chk("mid_rst_count", pair_count, 8'd0);
    chk("mid_rst_last", ob.out_last, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    dump_req = 1'b1;
    cyc();
    dump_req = 1'b0;
    repeat (5) cyc();
    chk("post_rst_dump_ignored", ob.out_valid, 1'b0);
    chk("post_rst_idle", collect_done, 1'b0);

    collect(10, 1);
    dump(1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
